// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_pkg
// Description : RV32M func3/func7 encodings shared by the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

    localparam logic [6:0] C_FUNC7_M = 7'b0000001;

    typedef enum logic [2:0] {
        C_F3_MUL    = 3'd0,
        C_F3_MULH   = 3'd1,
        C_F3_MULHSU = 3'd2,
        C_F3_MULHU  = 3'd3,
        C_F3_DIV    = 3'd4,
        C_F3_DIVU   = 3'd5,
        C_F3_REM    = 3'd6,
        C_F3_REMU   = 3'd7
    } muldiv_func3_e;

    function automatic logic f_is_m_op(input logic [6:0] func7);
        return func7 == C_FUNC7_M;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_div_iter
// Description : One restoring-division step: shift in the next dividend bit,
//               trial-subtract the divisor, keep the difference if non-negative.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_diff;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {2'b00, i_div};

    // The top bit of the difference is the borrow of the trial subtraction.
    always_comb begin
        if (!w_diff[XLEN+1]) begin
            o_rem = w_diff[XLEN:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end else begin
            o_rem = w_shift[XLEN:0];
            o_quo = {i_quo[XLEN-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Multi-cycle RV32M multiply/divide unit with pipeline hold.
//               Define EX_MULDIV_FAST_MUL_EN for single-cycle array multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int              CW          = $clog2(XLEN);
    localparam logic [CW-1:0]   C_LAST_STEP = CW'(XLEN - 1);
    localparam logic [1:0]      C_ST_IDLE   = 2'd0;
    localparam logic [1:0]      C_ST_BUSY   = 2'd1;
    localparam logic [1:0]      C_ST_DONE   = 2'd2;
    localparam logic [XLEN-1:0] C_MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state, w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_func3;
    logic [4:0]        r_rd_addr;
    logic [XLEN-1:0]   r_b, r_lo, r_result;
    logic [XLEN:0]     r_acc;
    logic              r_neg, r_rem_neg;

    logic              w_op1_signed, w_op2_signed, w_op1_neg, w_op2_neg;
    logic [XLEN-1:0]   w_mag1, w_mag2, w_idle_result, w_busy_result;
    logic              w_is_div, w_div_zero, w_div_ovf, w_single;
    logic [2*XLEN-1:0] w_fast_prod;
    logic [XLEN:0]     w_mul_sum, w_div_rem, w_step_acc;
    logic [XLEN-1:0]   w_div_quo, w_step_lo;

    // Sign-magnitude core: results are re-signed when loaded for DONE.
    function automatic logic [XLEN-1:0] f_format(
        input logic [2:0]      f3,
        input logic [2*XLEN-1:0] prod,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem,
        input logic            neg,
        input logic            rem_neg
    );
        logic [2*XLEN-1:0] w_sprod;
        logic [XLEN-1:0]   w_squo, w_srem;
        w_sprod = neg ? -prod : prod;
        w_squo  = neg ? -quo : quo;
        w_srem  = rem_neg ? -rem : rem;
        case (f3)
            C_F3_MUL:                          f_format = w_sprod[XLEN-1:0];
            C_F3_MULH, C_F3_MULHSU, C_F3_MULHU: f_format = w_sprod[2*XLEN-1:XLEN];
            C_F3_DIV, C_F3_DIVU:               f_format = w_squo;
            default:                           f_format = w_srem;
        endcase
    endfunction

    assign w_is_div     = func3_i[2];
    assign w_op1_signed = func3_i inside {C_F3_MUL, C_F3_MULH, C_F3_MULHSU, C_F3_DIV, C_F3_REM};
    assign w_op2_signed = func3_i inside {C_F3_MUL, C_F3_MULH, C_F3_DIV, C_F3_REM};
    assign w_op1_neg    = w_op1_signed & op1_i[XLEN-1];
    assign w_op2_neg    = w_op2_signed & op2_i[XLEN-1];
    assign w_mag1       = w_op1_neg ? -op1_i : op1_i;
    assign w_mag2       = w_op2_neg ? -op2_i : op2_i;
    assign w_div_zero   = w_is_div & (op2_i == '0);
    assign w_div_ovf    = ((func3_i == C_F3_DIV) || (func3_i == C_F3_REM)) &&
                          (op1_i == C_MOST_NEG) && (op2_i == '1);

`ifdef EX_MULDIV_FAST_MUL_EN
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_single    = w_div_zero | w_div_ovf | ~w_is_div;
`else
    assign w_fast_prod = '0;
    assign w_single    = w_div_zero | w_div_ovf;
`endif

    // Remainder ops sit at func3[1]=1 within the divide half.
    always_comb begin
        if (w_div_zero) begin
            w_idle_result = func3_i[1] ? op1_i : '1;
        end else if (w_div_ovf) begin
            w_idle_result = func3_i[1] ? '0 : op1_i;
        end else begin
            w_idle_result = f_format(func3_i, w_fast_prod, '0, '0,
                                     w_op1_neg ^ w_op2_neg, w_op1_neg);
        end
    end

    // Shift-add multiply shares the divider's {acc, lo} register pair.
    assign w_mul_sum  = r_acc + {1'b0, {XLEN{r_lo[0]}} & r_b};
    assign w_step_acc = r_func3[2] ? w_div_rem : {1'b0, w_mul_sum[XLEN:1]};
    assign w_step_lo  = r_func3[2] ? w_div_quo : {w_mul_sum[0], r_lo[XLEN-1:1]};
    assign w_busy_result = f_format(r_func3, {w_step_acc[XLEN-1:0], w_step_lo},
                                    w_step_lo, w_step_acc[XLEN-1:0], r_neg, r_rem_neg);

    ex_muldiv_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .i_rem (r_acc),
        .i_quo (r_lo),
        .i_div (r_b),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE: if (start_i) w_next_state = w_single ? C_ST_DONE : C_ST_BUSY;
            C_ST_BUSY: if (r_cnt == C_LAST_STEP) w_next_state = C_ST_DONE;
            default:   w_next_state = C_ST_IDLE;
        endcase
        if (flush_i) begin
            w_next_state = C_ST_IDLE;
        end
    end

    always_comb begin
        hold_flag_o = ((r_state == C_ST_IDLE) && start_i && !flush_i) || (r_state == C_ST_BUSY);
        valid_o     = (r_state == C_ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_func3   <= '0;
            r_rd_addr <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_result  <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (start_i) begin
                        r_func3   <= func3_i;
                        r_rd_addr <= rd_addr_i;
                        r_b       <= w_mag2;
                        r_acc     <= '0;
                        r_lo      <= w_mag1;
                        r_neg     <= w_op1_neg ^ w_op2_neg;
                        r_rem_neg <= w_op1_neg;
                        r_cnt     <= '0;
                        if (w_single) begin
                            r_result <= w_idle_result;
                        end
                    end
                end
                C_ST_BUSY: begin
                    r_acc <= w_step_acc;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST_STEP) begin
                        r_result <= w_busy_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o  = r_result;
    assign rd_addr_o = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Scoreboard bench for ex_muldiv against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      func3_i = '0;
    logic [XLEN-1:0] op1_i = '0;
    logic [XLEN-1:0] op2_i = '0;
    logic [4:0]      rd_addr_i = '0;
    logic            flush_i = 1'b0;
    logic            hold_flag_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .func3_i     (func3_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .flush_i     (flush_i),
        .hold_flag_o (hold_flag_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .rd_addr_o   (rd_addr_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] up;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin sp = sa * sb; return sp[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'({32'h0, b}); return sp[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 1;
            if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef EX_MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called just after a negedge; returns inside the result cycle.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int   lat;
        exp_t e;
        lat       = latency(f, a, b);
        start_i   = 1'b1;
        func3_i   = f;
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        e.res     = ref_op(f, a, b);
        e.rd      = rd;
        e.cyc     = cyc + lat;
        exp_q.push_back(e);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(negedge clk);
                start_i   = 1'b0;
                func3_i   = 3'($urandom);
                op1_i     = $urandom;
                op2_i     = $urandom;
                rd_addr_i = 5'($urandom);
            end
            #1 chk("hold_flag", hold_flag_o, (k < lat));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got result 0x%0h, expected no valid", result_o);
            end else begin
                m_e = exp_q.pop_front();
                chk("result", result_o, m_e.res);
                chk("rd_addr", rd_addr_o, m_e.rd);
                chk("valid_cycle", cyc, m_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1);
    end

    initial begin
        start_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valid", valid_o, 0);
        chk("reset_result", result_o, 0);
        chk("reset_rd", rd_addr_o, 0);
        chk("reset_hold_start", hold_flag_o, 1);
        start_i = 1'b0;
        #1 chk("reset_hold_idle", hold_flag_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk); issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        @(negedge clk); issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        @(negedge clk); issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        @(negedge clk); issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
        @(negedge clk); issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
        @(negedge clk); issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        @(negedge clk); issue(3'd5, 32'd5, 32'd0, 5'd7);
        @(negedge clk); issue(3'd7, 32'd5, 32'd0, 5'd8);
        @(negedge clk); issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        @(negedge clk); issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        @(negedge clk); issue(3'd7, 32'd100, 32'hFFFF_FFF9, 5'd13);

        // Flush at T+10 cancels the divide; a new request follows at T+11.
        @(negedge clk);
        start_i = 1'b1; func3_i = 3'd4; op1_i = 32'd1000; op2_i = 32'd7; rd_addr_i = 5'd12;
        #1 chk("flush_hold_start", hold_flag_o, 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            flush_i = (k == 10);
            #1 chk("flush_hold_busy", hold_flag_o, 1);
        end
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("flush_hold_after", hold_flag_o, 0);
        issue(3'd5, 32'd9, 32'd3, 5'd9);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start_i = 1'b1; func3_i = 3'd4; op1_i = 32'd1000; op2_i = 32'd7; rd_addr_i = 5'd17;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_valid", valid_o, 0);
        chk("midreset_result", result_o, 0);
        chk("midreset_rd", rd_addr_o, 0);
        chk("midreset_hold", hold_flag_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            @(negedge clk);
            issue(f, a, b, 5'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
